framebuffer_scanner: RTL and testbench
======================================

Name: framebuffer_scanner

Overview:
- Reader end of the 1200-bit game framebuffer. The display writer produces the framebuffer; this block consumes it.
- Snapshots the framebuffer once per frame at the start of vertical blank, so there is no tearing.
- Scans the snapshot as a 40x30 grid of 16x16-pixel cells.
- Generates 640x480@60 VGA timing and 4-bit red/green from the 50 MHz system clock.
- Also gives game logic a one-clock vblank_start strobe, marking a safe point to update state.

Parameters:
- FG_RED, 4'hF, red level for a set cell
- FG_GREEN, 4'hF, green level for a set cell
- BG_RED, 4'h0, red level for a clear cell
- BG_GREEN, 4'h0, green level for a clear cell

Ports:
- clock  input  1  50 MHz system clock
- reset_signal  input  1  asynchronous, active-low reset
- data  input  1200  framebuffer; bit index = row*40 + col, row 0..29, col 0..39
- red_out  output  4  red pixel level
- green_out  output  4  green pixel level
- h_sync_out  output  1  horizontal sync, active low
- v_sync_out  output  1  vertical sync, active low
- vblank_start  output  1  one-clock strobe when the snapshot is loaded

Behaviour:
- Reset (reset_signal low, async):
  - phase=0, hcount=0, vcount=0, shadow=0.
  - red_out=0, green_out=0, h_sync_out=1, v_sync_out=1, vblank_start=0.
- Pixel tick:
  - phase toggles every clock; tick = phase (true before the edge).
  - After reset release, edge 1 sets phase=1 with no tick; edge 2 is the first tick. Ticks occur on every even edge.
- Counters (advance only on tick):
  - hcount 0..799; at 799 wraps to 0 and vcount increments.
  - vcount 0..524; wraps to 0 after 524.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Outputs are registered on the tick edge and computed from the pre-increment counters (h, v):
  - h_sync_out = 0 iff 656 <= h <= 751.
  - v_sync_out = 0 iff 490 <= v <= 491.
  - Visible (h<640 and v<480): cell = shadow[(v>>4)*40 + (h>>4)]. Set cell -> FG_RED/FG_GREEN; clear cell -> BG_RED/BG_GREEN.
  - Not visible: red_out=0, green_out=0 (blanking is mandatory).
  - Outputs hold between ticks.
  - Pixel (h, v) appears on outputs after tick edge number v*800 + h + 1, i.e. clock edge 2*(v*800 + h + 1).
- Snapshot:
  - On the tick with h==0 and v==480, shadow <= data (captured on that edge).
  - vblank_start is 1 for exactly the following clock, 0 otherwise.
  - data changes at any other time do not affect the displayed frame until the next load.
- Index arithmetic: row = v[8:4] (0..29), col = h[9:4] (0..39). Index is at most 1199, never out of range in the visible area.
- Frame period: 840000 clocks; line period: 1600 clocks.
- Reset mid-frame: all state clears immediately; the scan restarts at (0,0) with a blank shadow. The first frame after reset shows BG only until the first load.
- No handshake on data: the writer must hold data stable on the load edge. Updating right after vblank_start satisfies this.

Test Plan:
- Reset: hold reset_signal low, toggle clock -> syncs=1, colors=0, vblank_start=0. Assert reset mid-line -> outputs return to reset values without a clock edge.
- Horizontal sync: release reset -> h_sync_out first falls at edge 1314 and rises at edge 1506. The next fall is at edge 2914 (period 1600).
- Vertical sync and strobe:
  - v_sync_out low from edge 2*(490*800+1)=784002 until edge 787202.
  - vblank_start high only for the clock after edge 768002.
  - Both repeat every 840000 clocks.
- Pixel mapping:
  - data = only bit 41 set (row1, col1); after the first load, in the next frame, pixels h16..31 x v16..31 show 4'hF/4'hF.
  - Pixels (15,16), (32,16) and (16,32) show 0/0.
  - Pixel (16,16) appears after edge 2*(16*800+16+1).
- Snapshot isolation: change data to all-ones at v=100 of frame 2 -> frame 2 is unchanged; frame 3 visible area is all FG; porches stay 0.
- Corner cell: only bit 1199 set -> only pixels h624..639, v464..479 show FG; h640 is 0.

Source files
------------

// File: rtl/framebuffer_scanner.sv
// Reader side of the 1200-bit cell framebuffer: snapshots it at vblank and scans it
// out as 16x16-pixel cells with VGA timing on a half-rate pixel tick.
module framebuffer_scanner #(
  parameter logic [3:0] FG_RED   = 4'hF,
  parameter logic [3:0] FG_GREEN = 4'hF,
  parameter logic [3:0] BG_RED   = 4'h0,
  parameter logic [3:0] BG_GREEN = 4'h0,
  // Raster geometry in pixels/lines; defaults give 640x480@60 from a 50 MHz clock
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic          clock,
  input  logic          reset_signal,
  input  logic [1199:0] data,
  output logic [3:0]    red_out,
  output logic [3:0]    green_out,
  output logic          h_sync_out,
  output logic          v_sync_out,
  output logic          vblank_start
);

  localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W   = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VIS + V_FP + V_SYNC);

  logic          phase_q, phase_d;
  logic [9:0]    hcount_q, hcount_d;
  logic [9:0]    vcount_q, vcount_d;
  logic [1199:0] shadow_q, shadow_d;
  logic [3:0]    red_q, red_d;
  logic [3:0]    green_q, green_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          vblank_q, vblank_d;
  logic          visible;
  logic [10:0]   cell_idx;
  logic          cell_on;

  always_comb begin
    phase_d  = ~phase_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    shadow_d = shadow_q;
    red_d    = red_q;
    green_d  = green_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    vblank_d = 1'b0;

    visible  = (hcount_q < H_VIS_W) && (vcount_q < V_VIS_W);
    // Index is only formed inside the visible area so it never leaves 0..1199
    cell_idx = visible ? ({6'd0, vcount_q[8:4]} * 11'd40 + {5'd0, hcount_q[9:4]}) : 11'd0;
    cell_on  = visible && shadow_q[cell_idx];

    if (phase_q) begin
      hcount_d = (hcount_q == H_LAST) ? 10'd0 : hcount_q + 10'd1;
      if (hcount_q == H_LAST) begin
        vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
      end
      hsync_d = !((hcount_q >= H_SYNC_LO) && (hcount_q < H_SYNC_HI));
      vsync_d = !((vcount_q >= V_SYNC_LO) && (vcount_q < V_SYNC_HI));
      red_d   = visible ? (cell_on ? FG_RED : BG_RED) : 4'h0;
      green_d = visible ? (cell_on ? FG_GREEN : BG_GREEN) : 4'h0;
      // First tick of vertical blank: take the frame the writer has finished
      if ((hcount_q == 10'd0) && (vcount_q == V_VIS_W)) begin
        shadow_d = data;
        vblank_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      phase_q  <= 1'b0;
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
      shadow_q <= '0;
      red_q    <= 4'h0;
      green_q  <= 4'h0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      vblank_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      shadow_q <= shadow_d;
      red_q    <= red_d;
      green_q  <= green_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
    end
  end

  assign red_out      = red_q;
  assign green_out    = green_q;
  assign h_sync_out   = hsync_q;
  assign v_sync_out   = vsync_q;
  assign vblank_start = vblank_q;

endmodule

// File: tb/tb_framebuffer_scanner.sv
// Bench for framebuffer_scanner: a full-size instance for line timing and a
// reduced-raster instance for whole-frame snapshot and cell-mapping behaviour.
module tb_framebuffer_scanner;

  localparam int SH_VIS = 64, SH_FP = 4, SH_SYNC = 8, SH_BP = 4;
  localparam int SV_VIS = 48, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
  localparam int SH_TOT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
  localparam int SV_TOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
  localparam int FRAME  = 2 * SH_TOT * SV_TOT;

  logic          clock;
  logic          reset_signal;
  logic [1199:0] data;
  logic [3:0]    s_red, s_green, f_red, f_green;
  logic          s_hs, s_vs, s_vbs, f_hs, f_vs, f_vbs;
  int            edge_cnt;
  int            checks;
  int            errors;

  typedef struct {
    int         edge_n;
    int         dut;
    int         fld;
    logic [3:0] exp;
    string      tag;
  } item_t;
  item_t sb[$];

  framebuffer_scanner #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) dut_small (
    .clock(clock), .reset_signal(reset_signal), .data(data),
    .red_out(s_red), .green_out(s_green), .h_sync_out(s_hs),
    .v_sync_out(s_vs), .vblank_start(s_vbs)
  );

  framebuffer_scanner dut_full (
    .clock(clock), .reset_signal(reset_signal), .data(data),
    .red_out(f_red), .green_out(f_green), .h_sync_out(f_hs),
    .v_sync_out(f_vs), .vblank_start(f_vbs)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) edge_cnt <= 0;
    else               edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [3:0] observe(int d, int f);
    logic [3:0] r;
    r = 4'h0;
    if (d == 0) begin
      case (f)
        0: r = s_red;
        1: r = s_green;
        2: r = {3'b0, s_hs};
        3: r = {3'b0, s_vs};
        default: r = {3'b0, s_vbs};
      endcase
    end else begin
      case (f)
        0: r = f_red;
        1: r = f_green;
        2: r = {3'b0, f_hs};
        3: r = {3'b0, f_vs};
        default: r = {3'b0, f_vbs};
      endcase
    end
    return r;
  endfunction

  function automatic void push(int e, int d, int f, logic [3:0] x, string t);
    item_t it;
    int i;
    it.edge_n = e;
    it.dut    = d;
    it.fld    = f;
    it.exp    = x;
    it.tag    = t;
    i = sb.size();
    while (i > 0 && sb[i-1].edge_n > e) i--;
    sb.insert(i, it);
  endfunction

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(int e);
    if (edge_cnt > e) begin
      checks++;
      errors++;
      $error("FAIL late_sample observed_edge=%0d expected_edge=%0d", edge_cnt, e);
    end
    while (edge_cnt < e) @(negedge clock);
  endtask

  task automatic drain_until(int e);
    item_t it;
    while (sb.size() > 0 && sb[0].edge_n <= e) begin
      it = sb.pop_front();
      wait_edge(it.edge_n);
      check(it.tag, observe(it.dut, it.fld), it.exp);
    end
    wait_edge(e);
  endtask

  // Expected small-raster pixel colour from the cell map (FG = F, BG = 0)
  function automatic logic [3:0] mdl_px(logic [1199:0] sh, int h, int v);
    if (h < SH_VIS && v < SV_VIS) return sh[(v / 16) * 40 + h / 16] ? 4'hF : 4'h0;
    return 4'h0;
  endfunction

  function automatic int px_edge(int f, int h, int v);
    return f * FRAME + 2 * (v * SH_TOT + h + 1);
  endfunction

  function automatic void push_frame(int f, logic [1199:0] sh, string nm);
    int e;
    logic hs, vs, vb;
    for (int v = 0; v < SV_TOT; v++) begin
      for (int h = 0; h < SH_TOT; h++) begin
        e  = px_edge(f, h, v);
        hs = !(h >= SH_VIS + SH_FP && h < SH_VIS + SH_FP + SH_SYNC);
        vs = !(v >= SV_VIS + SV_FP && v < SV_VIS + SV_FP + SV_SYNC);
        vb = (h == 0 && v == SV_VIS);
        push(e, 0, 0, mdl_px(sh, h, v), $sformatf("%s_red_h%0d_v%0d", nm, h, v));
        push(e, 0, 1, mdl_px(sh, h, v), $sformatf("%s_grn_h%0d_v%0d", nm, h, v));
        push(e, 0, 2, {3'b0, hs}, $sformatf("%s_hs_h%0d_v%0d", nm, h, v));
        push(e, 0, 3, {3'b0, vs}, $sformatf("%s_vs_h%0d_v%0d", nm, h, v));
        push(e, 0, 4, {3'b0, vb}, $sformatf("%s_vbs_h%0d_v%0d", nm, h, v));
      end
    end
  endfunction

  initial begin
    logic [1199:0] d41, d83, ones, blank;
    int load0;
    checks = 0;
    errors = 0;
    blank = '0;
    ones  = '1;
    d41 = '0;
    d41[41] = 1'b1;
    d83 = '0;
    d83[83] = 1'b1;
    load0 = 2 * (SV_VIS * SH_TOT + 1);

    reset_signal = 1'b0;
    data = blank;
    repeat (4) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_red_%0d", d), observe(d, 0), 4'h0);
      check($sformatf("rst_grn_%0d", d), observe(d, 1), 4'h0);
      check($sformatf("rst_hs_%0d", d),  observe(d, 2), 4'h1);
      check($sformatf("rst_vs_%0d", d),  observe(d, 3), 4'h1);
      check($sformatf("rst_vbs_%0d", d), observe(d, 4), 4'h0);
    end

    // Release; frame 0 shows a blank shadow, frame 1 shows cell (row1,col1)
    data = d41;
    reset_signal = 1'b1;
    push(1313, 1, 2, 4'h1, "full_hs_before_fall");
    push(1314, 1, 2, 4'h0, "full_hs_fall");
    push(1314, 1, 3, 4'h1, "full_vs_line0");
    push(1314, 1, 4, 4'h0, "full_vbs_line0");
    push(1505, 1, 2, 4'h0, "full_hs_before_rise");
    push(1506, 1, 2, 4'h1, "full_hs_rise");
    push(2913, 1, 2, 4'h1, "full_hs_before_fall2");
    push(2914, 1, 2, 4'h0, "full_hs_fall2");
    for (int h = 0; h < 100; h++) push(2 * (h + 1), 1, 0, 4'h0, $sformatf("full_red_h%0d", h));
    push_frame(0, blank, "f0");
    push(load0 - 1, 0, 4, 4'h0, "vbs_before_load0");
    push(load0 + 1, 0, 4, 4'h0, "vbs_after_load0");
    push_frame(1, d41, "f1");
    push(px_edge(1, 16, 16) - 1, 0, 0, 4'h0, "px16_16_not_yet");
    push(px_edge(1, 16, 16), 0, 0, 4'hF, "px16_16_appears");
    push(px_edge(1, 31, 31), 0, 1, 4'hF, "px31_31_grn");
    push(px_edge(1, 15, 16), 0, 0, 4'h0, "px15_16_clear");
    push(px_edge(1, 32, 16), 0, 0, 4'h0, "px32_16_clear");
    push(px_edge(1, 16, 32), 0, 0, 4'h0, "px16_32_clear");
    push(FRAME + load0 + 1, 0, 4, 4'h0, "vbs_after_load1");
    push_frame(2, d41, "f2");

    // Writer changes data mid-frame 2; frame 2 must not change
    drain_until(2 * FRAME + 2 * (20 * SH_TOT));
    data = ones;
    push_frame(3, ones, "f3");

    drain_until(3 * FRAME + 2 * (10 * SH_TOT));
    data = d83;
    push_frame(4, d83, "f4");
    push(px_edge(4, 48, 32), 0, 0, 4'hF, "corner_first_px");
    push(px_edge(4, 63, 47), 0, 0, 4'hF, "corner_last_px");
    push(px_edge(4, 64, 47), 0, 0, 4'h0, "corner_h_past_visible");
    push(px_edge(4, 47, 32), 0, 0, 4'h0, "corner_left_neighbour");

    // Asynchronous reset while a set cell is on screen
    drain_until(px_edge(4, 50, 40));
    sb.delete();
    #5;
    reset_signal = 1'b0;
    #1;
    check("midrst_red",  observe(0, 0), 4'h0);
    check("midrst_grn",  observe(0, 1), 4'h0);
    check("midrst_hs",   observe(0, 2), 4'h1);
    check("midrst_vs",   observe(0, 3), 4'h1);
    check("midrst_vbs",  observe(0, 4), 4'h0);
    check("midrst_fhs",  observe(1, 2), 4'h1);
    check("midrst_fvs",  observe(1, 3), 4'h1);
    check("midrst_fred", observe(1, 0), 4'h0);
    repeat (3) @(negedge clock);
    reset_signal = 1'b1;

    // Scan restarts at (0,0) with an empty shadow until the next load
    push(2 * (SH_VIS + SH_FP), 0, 2, 4'h1, "rs_hs_before_fall");
    push(2 * (SH_VIS + SH_FP + 1), 0, 2, 4'h0, "rs_hs_fall");
    push(px_edge(0, 48, 32), 0, 0, 4'h0, "rs_corner_blank");
    push(px_edge(0, 50, 40), 0, 0, 4'h0, "rs_corner_blank2");
    push(load0, 0, 4, 4'h1, "rs_vbs_load");
    push(px_edge(1, 48, 32), 0, 0, 4'hF, "rs_corner_after_load");
    drain_until(px_edge(1, 48, 32) + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
